// File: rtl/resp_frame_parser.sv
// Streaming parser for "RESP:<hex>\n" frames; result/error pulses are registered one cycle after the byte.
// No backpressure: accepts a byte every cycle; a timeout bounds the whole frame from arm.
module resp_frame_parser #(
  parameter int NUM_HEX        = 32,
  parameter int TIMEOUT_CYCLES = 60_000_000,
  parameter bit ALLOW_CR       = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 busy,
  output logic [4*NUM_HEX-1:0] resp_value,
  output logic                 resp_valid,
  output logic                 resp_err,
  output logic [2:0]           err_code
);
  localparam int VW = 4 * NUM_HEX;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW = $clog2(NUM_HEX + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(NUM_HEX - 1);

  typedef enum logic [1:0] {IDLE, PREFIX, HEX, TERM} state_t;

  state_t          state_q, state_d;
  logic [2:0]      pidx_q, pidx_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [VW-1:0]   shift_q, shift_d;
  logic            cr_q, cr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [VW-1:0]   value_q, value_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [2:0]      code_q, code_d;
  logic [4:0]      nib;

  function automatic logic [7:0] prefix_char(input logic [2:0] idx);
    case (idx)
      3'd0:    return "R";
      3'd1:    return "E";
      3'd2:    return "S";
      3'd3:    return "P";
      default: return ":";
    endcase
  endfunction

  // Bit 4 flags a legal hex digit; letters map via low nibble + 9.
  function automatic logic [4:0] hex_nib(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return {1'b1, b[3:0]};
    if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) return {1'b1, b[3:0] + 4'd9};
    return 5'd0;
  endfunction

  assign nib = hex_nib(rx_data);

  always_comb begin
    state_d = state_q;
    pidx_d  = pidx_q;
    dcnt_d  = dcnt_q;
    shift_d = shift_q;
    cr_d    = cr_q;
    timer_d = timer_q;
    value_d = value_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    if (arm) begin
      state_d = PREFIX;
      pidx_d  = '0;
      dcnt_d  = '0;
      shift_d = '0;
      cr_d    = 1'b0;
      timer_d = '0;
    end else if (state_q != IDLE) begin
      if (timer_q != '1) timer_d = timer_q + 1'b1;
      if (timer_q == T_LAST) begin
        err_d   = 1'b1;
        code_d  = 3'd4;
        state_d = IDLE;
      end else if (rx_valid) begin
        case (state_q)
          PREFIX: begin
            if (rx_data == prefix_char(pidx_q)) begin
              pidx_d = pidx_q + 3'd1;
              if (pidx_q == 3'd4) state_d = HEX;
            end else begin
              err_d   = 1'b1;
              code_d  = 3'd1;
              state_d = IDLE;
            end
          end
          HEX: begin
            if (nib[4]) begin
              shift_d = {shift_q[VW-5:0], nib[3:0]};
              dcnt_d  = dcnt_q + 1'b1;
              if (dcnt_q == D_LAST) state_d = TERM;
            end else begin
              err_d   = 1'b1;
              code_d  = 3'd2;
              state_d = IDLE;
            end
          end
          TERM: begin
            if (rx_data == 8'h0A) begin
              value_d = shift_q;
              valid_d = 1'b1;
              state_d = IDLE;
            end else if (ALLOW_CR && rx_data == 8'h0D && !cr_q) begin
              cr_d = 1'b1;
            end else begin
              err_d   = 1'b1;
              code_d  = 3'd3;
              state_d = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pidx_q  <= '0;
      dcnt_q  <= '0;
      shift_q <= '0;
      cr_q    <= 1'b0;
      timer_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      pidx_q  <= pidx_d;
      dcnt_q  <= dcnt_d;
      shift_q <= shift_d;
      cr_q    <= cr_d;
      timer_q <= timer_d;
      value_q <= value_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign resp_value = value_q;
  assign resp_valid = valid_q;
  assign resp_err   = err_q;
  assign err_code   = code_q;
endmodule

// File: tb/tb_resp_frame_parser.sv
// Two parsers (CR rejected / CR allowed) driven with the same byte stream and checked every cycle
// against a frame-level model that classifies the bytes received since the last arm.
module tb_resp_frame_parser;
  localparam int NH = 32;
  localparam int TO = 100;
  localparam int VW = 4 * NH;

  logic          clk = 1'b0;
  logic          rst_n, arm, rx_valid;
  logic [7:0]    rx_data;
  logic          busy_o  [2];
  logic [VW-1:0] val_o   [2];
  logic          vld_o   [2];
  logic          err_o   [2];
  logic [2:0]    code_o  [2];

  always #5 clk = ~clk;

  resp_frame_parser #(.NUM_HEX(NH), .TIMEOUT_CYCLES(TO), .ALLOW_CR(1'b0)) u_nocr (
    .clk(clk), .rst_n(rst_n), .arm(arm), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy_o[0]), .resp_value(val_o[0]), .resp_valid(vld_o[0]),
    .resp_err(err_o[0]), .err_code(code_o[0]));

  resp_frame_parser #(.NUM_HEX(NH), .TIMEOUT_CYCLES(TO), .ALLOW_CR(1'b1)) u_cr (
    .clk(clk), .rst_n(rst_n), .arm(arm), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy_o[1]), .resp_value(val_o[1]), .resp_valid(vld_o[1]),
    .resp_err(err_o[1]), .err_code(code_o[1]));

  // Reference model: bytes since arm, cycles since arm, per-instance expectations.
  byte unsigned  fq[$];
  byte unsigned  tx[$];
  int            age;
  bit            m_act [2];
  bit            m_vld [2];
  bit            m_err [2];
  logic [VW-1:0] m_val [2];
  logic [2:0]    m_code[2];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_hex(input byte unsigned b);
    return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
  endfunction

  function automatic int hex_digit(input byte unsigned b);
    if (b >= "a") return b - "a" + 10;
    if (b >= "A") return b - "A" + 10;
    return b - "0";
  endfunction

  // 0 = frame still incomplete, 5 = accepted, otherwise the expected cause code.
  function automatic int classify(input bit cr_ok);
    string pfx = "RESP:";
    for (int i = 0; i < fq.size(); i++) begin
      if (i < 5) begin
        if (fq[i] != pfx[i]) return 1;
      end else if (i < 5 + NH) begin
        if (!is_hex(fq[i])) return 2;
      end else if (i == 5 + NH) begin
        if (fq[i] == 8'h0A) return 5;
        if (!(cr_ok && fq[i] == 8'h0D)) return 3;
      end else begin
        return (fq[i] == 8'h0A) ? 5 : 3;
      end
    end
    return 0;
  endfunction

  function automatic logic [VW-1:0] payload();
    logic [VW-1:0] v = '0;
    for (int i = 0; i < NH; i++) v = v * 16 + VW'(hex_digit(fq[5 + i]));
    return v;
  endfunction

  task automatic model_step(input bit r, input bit a, input bit v, input byte unsigned d);
    int st;
    for (int i = 0; i < 2; i++) begin
      m_vld[i] = 1'b0;
      m_err[i] = 1'b0;
    end
    if (!r) begin
      fq.delete();
      age = 0;
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 1'b0; m_val[i] = '0; m_code[i] = '0;
      end
    end else if (a) begin
      fq.delete();
      age = 0;
      for (int i = 0; i < 2; i++) m_act[i] = 1'b1;
    end else if (m_act[0] || m_act[1]) begin
      if (age == TO - 1) begin
        for (int i = 0; i < 2; i++)
          if (m_act[i]) begin
            m_err[i] = 1'b1; m_code[i] = 3'd4; m_act[i] = 1'b0;
          end
      end else if (v) begin
        fq.push_back(d);
        for (int i = 0; i < 2; i++)
          if (m_act[i]) begin
            st = classify(i == 1);
            if (st == 5) begin
              m_vld[i] = 1'b1; m_val[i] = payload(); m_act[i] = 1'b0;
            end else if (st != 0) begin
              m_err[i] = 1'b1; m_code[i] = 3'(st); m_act[i] = 1'b0;
            end
          end
      end
      age++;
    end
  endtask

  task automatic step(input bit r, input bit a, input bit v, input byte unsigned d);
    rst_n = r; arm = a; rx_valid = v; rx_data = d;
    model_step(r, a, v, d);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy%0d", i),  VW'(busy_o[i]), VW'(m_act[i]));
      chk($sformatf("valid%0d", i), VW'(vld_o[i]),  VW'(m_vld[i]));
      chk($sformatf("err%0d", i),   VW'(err_o[i]),  VW'(m_err[i]));
      chk($sformatf("code%0d", i),  VW'(code_o[i]), VW'(m_code[i]));
      chk($sformatf("value%0d", i), val_o[i],       m_val[i]);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) tx.push_back(s[i]);
  endtask

  // mode 0 plain, 1 re-arm (with a colliding byte) mid-stream, 2 reset mid-stream.
  task automatic send_tx(input int gmax, input int mode);
    int cut = (tx.size() > 0) ? $urandom_range(0, tx.size() - 1) : 0;
    for (int i = 0; i < tx.size(); i++) begin
      if (mode == 1 && i == cut) step(1'b1, 1'b1, 1'b1, "R");
      if (mode == 2 && i == cut) step(1'b0, 1'b0, 1'b1, tx[i]);
      step(1'b1, 1'b0, 1'b1, tx[i]);
      idle($urandom_range(0, gmax));
    end
    tx.delete();
  endtask

  task automatic add_digits(input int n);
    string hc = "0123456789abcdefABCDEF";
    for (int i = 0; i < n; i++) tx.push_back(hc[$urandom_range(0, 21)]);
  endtask

  task automatic add_nonhex();
    byte unsigned c;
    do c = 8'($urandom); while (is_hex(c));
    tx.push_back(c);
  endtask

  initial begin
    string pfx = "RESP:";
    byte unsigned c;
    int p, kind;
    rst_n = 1'b0; arm = 1'b0; rx_valid = 1'b0; rx_data = '0;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, "R");

    // Mixed-case full frame.
    step(1'b1, 1'b1, 1'b0, 8'h00);
    add_str("RESP:0123456789ABCDEFfedcba9876543210"); tx.push_back(8'h0A);
    send_tx(0, 0);
    chk("t1_value", val_o[1], 128'h0123456789ABCDEFFEDCBA9876543210);
    idle(2);
    // CR before LF: accepted by one instance, TERM error on the other.
    step(1'b1, 1'b1, 1'b0, 8'h00);
    add_str("RESP:AAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA"); tx.push_back(8'h0D); tx.push_back(8'h0A);
    send_tx(0, 0);
    idle(2);
    // Bad prefix, trailing bytes ignored.
    step(1'b1, 1'b1, 1'b0, 8'h00);
    add_str("RESQ:1234"); send_tx(0, 0);
    // Bad hex digit, then short payload ended early by LF.
    step(1'b1, 1'b1, 1'b0, 8'h00);
    add_str("RESP:12G"); send_tx(0, 0);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    add_str("RESP:"); add_digits(31); tx.push_back(8'h0A); send_tx(0, 0);
    // Timeout after a partial prefix.
    step(1'b1, 1'b1, 1'b0, 8'h00);
    add_str("RES"); send_tx(0, 0);
    idle(TO + 5);
    // Re-arm mid-frame, then a good frame.
    step(1'b1, 1'b1, 1'b0, 8'h00);
    add_str("RESP:12"); send_tx(0, 0);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    add_str("RESP:"); add_digits(NH); tx.push_back(8'h0A); send_tx(0, 0);
    // Reset mid-frame.
    step(1'b1, 1'b1, 1'b0, 8'h00);
    add_str("RESP:1234"); send_tx(0, 0);
    step(1'b0, 1'b0, 1'b1, "5");
    idle(3);

    for (int f = 0; f < 200; f++) begin
      kind = $urandom_range(0, 7);
      add_str("RESP:");
      case (kind)
        0, 1: begin add_digits(NH); tx.push_back(8'h0A); end
        2: begin add_digits(NH); tx.push_back(8'h0D); tx.push_back(8'h0A); end
        3: begin
          p = $urandom_range(0, 4);
          do c = 8'($urandom); while (c == pfx[p]);
          tx[p] = c;
          add_digits(NH); tx.push_back(8'h0A);
        end
        4: begin add_digits($urandom_range(0, NH - 1)); add_nonhex(); add_digits(4); end
        5: begin add_digits($urandom_range(0, NH - 1)); tx.push_back(8'h0A); end
        6: begin add_digits(NH); tx.push_back(8'h0D); tx.push_back(8'h0D); tx.push_back(8'h0A); end
        default: begin tx.delete(); add_str("RESP"); end
      endcase
      step(1'b1, 1'b1, 1'b0, 8'h00);
      p = $urandom_range(0, 19);
      send_tx($urandom_range(0, 2), (p == 0) ? 2 : (p < 3) ? 1 : 0);
      if (kind == 7) idle(TO + 2);
      else idle($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) step(1'b1, 1'b0, 1'b1, 8'($urandom));
    end

    step(1'b0, 1'b0, 1'b0, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
